// File: rtl/adventure_engine_if.sv
// Board-side bundle for the adventure engine: button request, board tables and game outputs.
// The master drives the request and tables; the slave (engine) drives the game state.
interface adventure_engine_if #(
    parameter int NUM_ROOMS = 8,
    parameter int NUM_ITEMS = 2
);
    localparam int RW = (NUM_ROOMS > 2) ? $clog2(NUM_ROOMS) : 1;
    localparam int IW = (NUM_ITEMS > 1) ? $clog2(NUM_ITEMS) : 1;
    localparam int MW = 8;

    logic                        dir_valid;
    logic [1:0]                  dir;
    logic [NUM_ROOMS*4*RW-1:0]   map_next;
    logic [NUM_ROOMS*(2+IW)-1:0] room_attr;
    logic [RW-1:0]               room;
    logic [NUM_ITEMS-1:0]        inventory;
    logic [1:0]                  status;
    logic [MW-1:0]               move_count;
    logic                        tick;
    logic                        moved;

    modport master (
        output dir_valid, dir, map_next, room_attr,
        input  room, inventory, status, move_count, tick, moved
    );

    modport slave (
        input  dir_valid, dir, map_next, room_attr,
        output room, inventory, status, move_count, tick, moved
    );
endinterface

// File: rtl/adventure_engine.sv
// Table-driven room-graph game engine: press capture, tick divider and move/guard/exit rules.
// The board comes in as flat map/attribute vectors; game state only advances on tick.
module adventure_engine #(
    parameter int NUM_ROOMS  = 8,
    parameter int NUM_ITEMS  = 2,
    parameter int START_ROOM = 0,
    parameter int TICK_DIV   = 25000000,
    parameter int MAX_MOVES  = 0
) (
    input logic              clk,
    input logic              reset,
    adventure_engine_if.slave bus
);
    localparam int RW = (NUM_ROOMS > 2) ? $clog2(NUM_ROOMS) : 1;
    localparam int IW = (NUM_ITEMS > 1) ? $clog2(NUM_ITEMS) : 1;
    localparam int AW = 2 + IW;
    localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int MW = 8;

    typedef enum logic [1:0] {
        ST_PLAY         = 2'd0,
        ST_WON          = 2'd1,
        ST_DEAD_GUARD   = 2'd2,
        ST_DEAD_TIMEOUT = 2'd3
    } status_t;

    typedef enum logic [1:0] {
        K_PLAIN = 2'd0,
        K_ITEM  = 2'd1,
        K_GUARD = 2'd2,
        K_EXIT  = 2'd3
    } kind_t;

    logic [CW-1:0]        div_cnt;
    logic                 wrap;
    logic                 dir_valid_p1;
    logic                 press_edge;
    logic                 pend_vld;
    logic [1:0]           pend_dir;
    logic                 tick_q, moved_q, moved_nxt;
    status_t              status_q, status_nxt;
    logic [RW-1:0]        room_q, room_nxt;
    logic [NUM_ITEMS-1:0] inv_q, inv_nxt;
    logic [MW-1:0]        mc_q, mc_nxt;
    logic                 guard_chk_q, guard_chk_nxt;

    logic [AW-1:0]        cur_attr, tgt_attr;
    logic [RW-1:0]        target;
    logic                 tgt_ok;
    kind_t                cur_kind, tgt_kind;
    logic [IW-1:0]        cur_item, tgt_item;

    // An item index beyond the inventory is never held, so such a guard always kills.
    function automatic logic item_held(input logic [NUM_ITEMS-1:0] inv, input logic [IW-1:0] idx);
        return (int'(idx) < NUM_ITEMS) && inv[idx];
    endfunction

    assign wrap       = (div_cnt == CW'(TICK_DIV - 1));
    assign press_edge = bus.dir_valid && !dir_valid_p1;

    always_comb begin
        status_nxt    = status_q;
        room_nxt      = room_q;
        inv_nxt       = inv_q;
        mc_nxt        = mc_q;
        guard_chk_nxt = guard_chk_q;
        moved_nxt     = 1'b0;

        cur_attr = bus.room_attr[int'(room_q)*AW +: AW];
        cur_kind = kind_t'(cur_attr[AW-1 -: 2]);
        cur_item = cur_attr[IW-1:0];
        target   = bus.map_next[(int'(room_q)*4 + int'(pend_dir))*RW +: RW];
        tgt_ok   = (int'(target) < NUM_ROOMS) && (target != room_q);
        tgt_attr = tgt_ok ? bus.room_attr[int'(target)*AW +: AW] : '0;
        tgt_kind = kind_t'(tgt_attr[AW-1 -: 2]);
        tgt_item = tgt_attr[IW-1:0];

        if (wrap) begin
            guard_chk_nxt = 1'b0;
            if (status_q == ST_PLAY) begin
                // A guard is judged one tick after entry; surviving it leaves the room usable at once.
                if (guard_chk_q && cur_kind == K_GUARD && !item_held(inv_q, cur_item)) begin
                    status_nxt = ST_DEAD_GUARD;
                end else if (pend_vld && tgt_ok) begin
                    room_nxt  = target;
                    moved_nxt = 1'b1;
                    mc_nxt    = (mc_q == '1) ? mc_q : mc_q + 1'b1;
                    case (tgt_kind)
                        K_ITEM:  if (int'(tgt_item) < NUM_ITEMS) inv_nxt[tgt_item] = 1'b1;
                        K_GUARD: guard_chk_nxt = 1'b1;
                        K_EXIT:  status_nxt = ST_WON;
                        default: ;
                    endcase
                    if (status_nxt != ST_WON && MAX_MOVES != 0 && mc_nxt == MW'(MAX_MOVES))
                        status_nxt = ST_DEAD_TIMEOUT;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            div_cnt      <= '0;
            tick_q       <= 1'b0;
            moved_q      <= 1'b0;
            dir_valid_p1 <= 1'b0;
            pend_vld     <= 1'b0;
            status_q     <= ST_PLAY;
            room_q       <= RW'(START_ROOM);
            inv_q        <= '0;
            mc_q         <= '0;
            guard_chk_q  <= 1'b1;
        end else begin
            div_cnt      <= wrap ? '0 : div_cnt + 1'b1;
            tick_q       <= wrap;
            moved_q      <= moved_nxt;
            dir_valid_p1 <= bus.dir_valid;
            // A fresh press beats the tick's consumption, so it waits for the following tick.
            if (press_edge)
                pend_vld <= 1'b1;
            else if (wrap)
                pend_vld <= 1'b0;
            status_q     <= status_nxt;
            room_q       <= room_nxt;
            inv_q        <= inv_nxt;
            mc_q         <= mc_nxt;
            guard_chk_q  <= guard_chk_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (press_edge)
            pend_dir <= bus.dir;
    end

    assign bus.room       = room_q;
    assign bus.inventory  = inv_q;
    assign bus.status     = status_q;
    assign bus.move_count = mc_q;
    assign bus.tick       = tick_q;
    assign bus.moved      = moved_q;
endmodule

// File: doc/adventure_engine.md
Name: adventure_engine

Overview:
- Parametrised, table-driven room-graph game engine. It generalises the fixed seven-room adventure FSM to N rooms, M collectible items, guard rooms keyed to specific items, and a move limit.
- The room map and room attributes arrive as flat input vectors, so one engine serves any board.
- It sits between the button decode/debounce logic and the HEX/LED display decoders.
- Game logic advances only on internal tick strobes.

Parameters:
- NUM_ROOMS, 8: number of rooms (≥2). RW = max(1, clog2(NUM_ROOMS)).
- NUM_ITEMS, 2: number of collectible items (≥1). IW = max(1, clog2(NUM_ITEMS)).
- START_ROOM, 0: room index after reset.
- TICK_DIV, 25000000: clk cycles per game tick (≥1; 1 = every cycle).
- MAX_MOVES, 0: move limit; 0 = unlimited. MW = 8.

Ports:
- clk, in, 1: system clock.
- reset, in, 1: synchronous, active-high; clock clk.
- dir_valid, in, 1: direction button held (level).
- dir, in, 2: N=0, E=1, S=2, W=3; sampled only with dir_valid.
- map_next, in, NUM_ROOMS*4*RW: neighbour of room r in direction d at bits [(r*4+d)*RW +: RW]. A value equal to r means wall.
- room_attr, in, NUM_ROOMS*(2+IW): room r at [r*(2+IW) +: 2+IW]. Field {kind[1:0], item[IW-1:0]}; kind 0=PLAIN, 1=ITEM, 2=GUARD, 3=EXIT.
- room, out, RW: current room.
- inventory, out, NUM_ITEMS: one bit per held item.
- status, out, 2: 0=PLAY, 1=WON, 2=DEAD_GUARD, 3=DEAD_TIMEOUT.
- move_count, out, MW: accepted moves, saturating at 255.
- tick, out, 1: one-cycle game-tick strobe.
- moved, out, 1: one-cycle pulse, coincident with tick, when room changed.

Behaviour:
- Reset values: room=START_ROOM, inventory=0, status=PLAY, move_count=0, tick=0, moved=0, pending request cleared, tick divider=0, press-edge history=0. Reset overrides every other event in the same cycle.
- Tick divider:
  - counts 0..TICK_DIV-1 and asserts tick in the wrap cycle;
  - ticks keep running in all statuses.
- Press capture:
  - Rising edge of dir_valid (registered vs previous cycle) loads pending={1,dir}.
  - Holding the button produces exactly one request; it must be released before another press is captured.
  - A new edge before consumption overwrites pending (latest wins).
  - An edge in a tick cycle stays pending for the next tick. The tick uses the registered pending value.
- On tick with status=PLAY and pending valid: pending is cleared and t = map_next[room][pending dir].
  - t==room (wall): no room change, move_count unchanged, moved=0.
  - Otherwise: room<=t, move_count+1 (saturating), moved=1.
  - Entering ITEM room: inventory[item] <= 1 on the same edge. Re-entry is harmless.
  - Entering GUARD room: evaluated on the next tick regardless of pending. If inventory[item]==1, status stays PLAY and the room is usable normally. Otherwise status<=DEAD_GUARD. The item check uses inventory at that tick.
  - Entering EXIT room: status<=WON on the same edge.
  - MAX_MOVES≠0 and the new move_count==MAX_MOVES with status not set to WON on this edge: status<=DEAD_TIMEOUT. WON has priority when both occur on the same edge.
- GUARD rule also applies to START_ROOM: if it is a GUARD room, it is checked at the first tick after reset.
- Tick with no pending request: no change except a pending GUARD check.
- WON/DEAD_*: terminal. Room, inventory and move_count are frozen, presses are ignored and pending is cleared each tick. Only reset leaves a terminal status.
- Out-of-range map entries (≥NUM_ROOMS) are treated as wall.
- Item index ≥NUM_ITEMS: the pickup is ignored and a GUARD with that index always kills.

Test Plan:
Default bench map for all scenarios: 7 rooms, TICK_DIV=4. Room 0 E→1; room 1 W→0, S→2; room 2 N→1, W→3, E→4; room 3 ITEM item0, E→2; room 4 GUARD item0, E→5; room 5 EXIT. All other directions are walls.
1. Reset, then press E held 20 cycles → exactly one move: room=1, move_count=1, moved pulses once, coincident with tick.
2. From room 0, press N (wall) → room=0, move_count=0, moved=0, status=PLAY.
3. Path E,S,E → room=4; the following tick gives status=DEAD_GUARD, room frozen at 4, and later presses are ignored.
4. Path E,S,W,E,E,E → inventory=2'b01 after W; room 4 survives its check; final room=5, status=WON, move_count=6.
5. MAX_MOVES=3, path E,S,N → status=DEAD_TIMEOUT on the third move edge, room=1.
6. Assert reset mid-game in room 3 with inventory=01 → next cycle room=0, inventory=0, status=PLAY, move_count=0, and a pending press is discarded.
